// File: rtl/digit_serializer_mux.sv
// digit_serializer_mux: captures an operand and streams it one digit per valid/ready transfer, LSB- or MSB-first.
// Define DIGIT_SERIALIZER_ZERO_SKIP_EN to skip leading zero digits in either order.
module digit_serializer_mux #(
    parameter  int DIGIT_W    = 4,
    parameter  int NUM_DIGITS = 16,
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_data,
    input  logic                          msb_first,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DIGIT_W-1:0]            out_digit,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last,
    output logic                          busy
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t                          state_q;
    logic [NUM_DIGITS*DIGIT_W-1:0]   opnd_q;
    logic                            msb_q;
    logic [IDX_W-1:0]                idx_q;
    logic [IDX_W-1:0]                idx_d;
    logic [IDX_W-1:0]                start_idx;
    logic                            last_base;

    assign busy       = (state_q == SHIFT);
    assign out_valid  = busy;
    assign load_ready = (state_q == IDLE);
    assign out_index  = idx_q;
    assign out_digit  = opnd_q[idx_q*DIGIT_W +: DIGIT_W];

`ifdef DIGIT_SERIALIZER_ZERO_SKIP_EN
    logic                            any_above;
    logic [IDX_W-1:0]                hi_nz;
    always_comb begin
        any_above = 1'b0;
        hi_nz     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k > int'(idx_q) && |opnd_q[k*DIGIT_W +: DIGIT_W]) any_above = 1'b1;
            if (|load_data[k*DIGIT_W +: DIGIT_W]) hi_nz = IDX_W'(k);
        end
        idx_d     = msb_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
        last_base = msb_q ? (idx_q == '0) : (idx_q == LAST_IDX);
        // LSB-first ends early once nothing nonzero remains above the current digit
        out_last  = busy & (last_base | (!msb_q & !any_above));
        start_idx = msb_first ? hi_nz : '0;
    end
`else
    always_comb begin
        idx_d     = msb_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
        last_base = msb_q ? (idx_q == '0) : (idx_q == LAST_IDX);
        out_last  = busy & last_base;
        start_idx = msb_first ? LAST_IDX : '0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            msb_q   <= 1'b0;
            idx_q   <= '0;
        end else if (state_q == IDLE) begin
            if (load_valid && !flush) begin
                opnd_q  <= load_data;
                msb_q   <= msb_first;
                idx_q   <= start_idx;
                state_q <= SHIFT;
            end
        end else if (flush || (out_ready && out_last)) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else if (out_ready) begin
            idx_q <= idx_d;
        end
    end
endmodule

// File: tb/tb_digit_serializer_mux.sv
// tb_digit_serializer_mux: directed checks of ordering, backpressure, flush, async reset and zero skipping.
module tb_digit_serializer_mux;
    localparam logic [63:0] OP = 64'hFEDC_BA98_7654_3210;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [63:0] load_data = '0;
    logic        msb_first = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_digit;
    logic [3:0]  out_index;
    logic        out_last;
    logic        busy;
    logic [9:0]  got;
    logic [9:0]  exp;
    int          tests = 0;
    int          fails = 0;

    digit_serializer_mux #(.DIGIT_W(4), .NUM_DIGITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .msb_first(msb_first), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    assign got = {out_valid, out_digit, out_index, out_last};

    task automatic load_op(input logic [63:0] op, input logic msb);
        @(negedge clk);
        load_data  = op;
        msb_first  = msb;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = ~op;
        msb_first  = ~msb;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++;
        if ({out_valid, out_index, out_last, busy, load_ready} !== 8'b0_0000_0_0_1) begin
            fails++;
            $display("FAIL reset: got v/idx/last/busy/lrdy=%b want 00000001", {out_valid, out_index, out_last, busy, load_ready});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lsb;
        load_op(OP, 1'b0);
        for (int i = 0; i < 16; i++) begin
            exp = {1'b1, 4'(i), 4'(i), i == 15};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL lsb[%0d]: got %h want %h", i, got, exp);
            end
            @(negedge clk);
        end
        tests++;
        if ({out_valid, load_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL lsb_end: got v/lrdy/busy=%b want 010", {out_valid, load_ready, busy});
        end
    endtask

    task automatic test_msb;
        load_op(OP, 1'b1);
        for (int i = 0; i < 16; i++) begin
            exp = {1'b1, 4'(15 - i), 4'(15 - i), i == 15};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL msb[%0d]: got %h want %h", i, got, exp);
            end
            @(negedge clk);
        end
        tests++;
        if ({out_valid, load_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL msb_end: got v/lrdy/busy=%b want 010", {out_valid, load_ready, busy});
        end
    endtask

    task automatic test_backpressure;
        load_op(OP, 1'b0);
        for (int i = 0; i < 16; i++) begin
            exp = {1'b1, 4'(i), 4'(i), i == 15};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL bp[%0d]: got %h want %h", i, got, exp);
            end
            if (i == 5) begin
                out_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    tests++;
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL bp_hold[%0d]: got %h want %h", h, got, exp);
                    end
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        tests++;
        if ({out_valid, load_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL bp_end: got v/lrdy/busy=%b want 010", {out_valid, load_ready, busy});
        end
    endtask

    task automatic test_flush;
        load_op(OP, 1'b0);
        repeat (7) @(negedge clk);
        exp = {1'b1, 4'd7, 4'd7, 1'b0};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL flush_pre: got %h want %h", got, exp);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests++;
        if ({out_valid, load_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL flush_idle: got v/lrdy/busy=%b want 010", {out_valid, load_ready, busy});
        end
        load_op(64'h1111_1111_1111_1111, 1'b0);
        for (int i = 0; i < 16; i++) begin
            exp = {1'b1, 4'h1, 4'(i), i == 15};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL flush_ones[%0d]: got %h want %h", i, got, exp);
            end
            @(negedge clk);
        end
        flush      = 1'b1;
        load_valid = 1'b1;
        load_data  = OP;
        @(negedge clk);
        flush      = 1'b0;
        load_valid = 1'b0;
        for (int h = 0; h < 2; h++) begin
            tests++;
            if ({out_valid, load_ready, busy} !== 3'b010) begin
                fails++;
                $display("FAIL flush_load[%0d]: got v/lrdy/busy=%b want 010", h, {out_valid, load_ready, busy});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset;
        load_op(OP, 1'b0);
        repeat (9) @(negedge clk);
        exp = {1'b1, 4'd9, 4'd9, 1'b0};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL arst_pre: got %h want %h", got, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, busy, out_index, out_last, load_ready} !== 8'b0_0_0000_0_1) begin
            fails++;
            $display("FAIL arst: got v/busy/idx/last/lrdy=%b want 00000001", {out_valid, busy, out_index, out_last, load_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({out_valid, load_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL arst_post: got v/lrdy/busy=%b want 010", {out_valid, load_ready, busy});
        end
    endtask

    task automatic test_zero_skip;
        logic [63:0] ops[4];
        logic        msbs[4];
        int          n[4];
        int          start[4];
        int          idx;
        ops  = '{64'hA3, 64'hA3, 64'h0, 64'h0};
        msbs = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef DIGIT_SERIALIZER_ZERO_SKIP_EN
        n     = '{2, 2, 1, 1};
        start = '{0, 1, 0, 0};
`else
        n     = '{16, 16, 16, 16};
        start = '{0, 15, 0, 15};
`endif
        for (int c = 0; c < 4; c++) begin
            load_op(ops[c], msbs[c]);
            for (int i = 0; i < n[c]; i++) begin
                idx = msbs[c] ? start[c] - i : i;
                exp = {1'b1, ops[c][idx*4 +: 4], 4'(idx), i == n[c] - 1};
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL zskip[%0d][%0d]: got %h want %h", c, i, got, exp);
                end
                @(negedge clk);
            end
            tests++;
            if ({out_valid, load_ready, busy} !== 3'b010) begin
                fails++;
                $display("FAIL zskip_end[%0d]: got v/lrdy/busy=%b want 010", c, {out_valid, load_ready, busy});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_lsb;
        test_msb;
        test_backpressure;
        test_flush;
        test_async_reset;
        test_zero_skip;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
